// File: rtl/b4_unit_param.sv
// Radix-4 DIT butterfly, four-stage pipeline with forward/inverse
// rotation, scaling, round-half-up, saturation and overflow flags.
module b4_unit_param #(
  parameter int WORDLENGTH_IO = 16,
  parameter int WORDLENGTH_WP = 9,
  parameter int ACC_W = WORDLENGTH_IO + WORDLENGTH_WP + 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     in_valid,
  input  logic                     inv,
  input  logic [1:0]               scale_sel,
  input  logic [WORDLENGTH_IO-1:0] ar,
  input  logic [WORDLENGTH_IO-1:0] ai,
  input  logic [WORDLENGTH_IO-1:0] br,
  input  logic [WORDLENGTH_IO-1:0] bi,
  input  logic [WORDLENGTH_IO-1:0] cr,
  input  logic [WORDLENGTH_IO-1:0] ci,
  input  logic [WORDLENGTH_IO-1:0] dr,
  input  logic [WORDLENGTH_IO-1:0] di,
  input  logic [WORDLENGTH_WP-1:0] w1pr,
  input  logic [WORDLENGTH_WP-1:0] w1pi,
  input  logic [WORDLENGTH_WP-1:0] w2pr,
  input  logic [WORDLENGTH_WP-1:0] w2pi,
  input  logic [WORDLENGTH_WP-1:0] w3pr,
  input  logic [WORDLENGTH_WP-1:0] w3pi,
  output logic                     out_valid,
  output logic [WORDLENGTH_IO-1:0] er,
  output logic [WORDLENGTH_IO-1:0] ei,
  output logic [WORDLENGTH_IO-1:0] fr,
  output logic [WORDLENGTH_IO-1:0] fi,
  output logic [WORDLENGTH_IO-1:0] gr,
  output logic [WORDLENGTH_IO-1:0] gi,
  output logic [WORDLENGTH_IO-1:0] hr,
  output logic [WORDLENGTH_IO-1:0] hi,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output logic                     ovf_sticky
);

  localparam int IO = WORDLENGTH_IO;
  localparam int WP = WORDLENGTH_WP;
  localparam int PW = IO + WP;

  localparam logic signed [ACC_W:0] ONE = (ACC_W+1)'(1);
  localparam int SH0 = WP - 1;
  localparam int SH1 = WP;
  localparam int SH2 = WP + 1;
  localparam logic signed [ACC_W:0] RND0 = ONE <<< (SH0 - 1);
  localparam logic signed [ACC_W:0] RND1 = ONE <<< (SH1 - 1);
  localparam logic signed [ACC_W:0] RND2 = ONE <<< (SH2 - 1);
  localparam logic signed [ACC_W:0] MAXV = (ONE <<< (IO - 1)) - ONE;
  localparam logic signed [ACC_W:0] MINV = -(ONE <<< (IO - 1));

  typedef logic signed [PW-1:0]    prod_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef struct packed {
    logic       v;
    logic       inv;
    logic [1:0] sc;
  } side_t;

  typedef struct packed {
    side_t s;
    prod_t ar, ai;
    prod_t brr, bii, bri, bir;
    prod_t crr, cii, cri, cir;
    prod_t drr, dii, dri, dir;
  } s1_t;

  typedef struct packed {
    side_t s;
    acc_t  apc_r, apc_i;
    acc_t  amc_r, amc_i;
    acc_t  bpd_r, bpd_i;
    acc_t  bmd_r, bmd_i;
  } s2_t;

  typedef struct packed {
    logic       v;
    logic [1:0] sc;
    acc_t       er, ei, fr, fi;
    acc_t       gr, gi, hr, hi;
  } s3_t;

  typedef struct packed {
    logic          v;
    logic          ovf;
    logic [IO-1:0] er, ei, fr, fi;
    logic [IO-1:0] gr, gi, hr, hi;
  } s4_t;

  s1_t s1, s1_d;
  s2_t s2, s2_d;
  s3_t s3, s3_d;
  s4_t s4, s4_d;

  acc_t a_r, a_i, b_r, b_i;
  acc_t c_r, c_i, d_r, d_i;
  acc_t f_r, f_i, h_r, h_i;
  logic [7:0][IO:0] rs;

  function automatic prod_t mul(
    input logic signed [IO-1:0] x,
    input logic signed [WP-1:0] w
  );
    return PW'(x) * PW'(w);
  endfunction

  // Returns {saturated, value}; shift is Q1.(WP-1) plus the extra scale.
  function automatic logic [IO:0] rnd_sat(
    input acc_t       x,
    input logic [1:0] sc
  );
    logic signed [ACC_W:0] t;
    logic                  up;
    logic                  dn;
    t = {x[ACC_W-1], x};
    unique case (sc)
      2'd0:    t = (t + RND0) >>> SH0;
      2'd1:    t = (t + RND1) >>> SH1;
      default: t = (t + RND2) >>> SH2;
    endcase
    up = t > MAXV;
    dn = t < MINV;
    if (up)
      return {1'b1, MAXV[IO-1:0]};
    else if (dn)
      return {1'b1, MINV[IO-1:0]};
    else
      return {1'b0, t[IO-1:0]};
  endfunction

  always_comb begin
    s1_d       = '0;
    s1_d.s.v   = in_valid;
    s1_d.s.inv = inv;
    s1_d.s.sc  = scale_sel;
    s1_d.ar    = PW'($signed(ar)) <<< (WP - 1);
    s1_d.ai    = PW'($signed(ai)) <<< (WP - 1);
    s1_d.brr   = mul(br, w1pr);
    s1_d.bii   = mul(bi, w1pi);
    s1_d.bri   = mul(br, w1pi);
    s1_d.bir   = mul(bi, w1pr);
    s1_d.crr   = mul(cr, w2pr);
    s1_d.cii   = mul(ci, w2pi);
    s1_d.cri   = mul(cr, w2pi);
    s1_d.cir   = mul(ci, w2pr);
    s1_d.drr   = mul(dr, w3pr);
    s1_d.dii   = mul(di, w3pi);
    s1_d.dri   = mul(dr, w3pi);
    s1_d.dir   = mul(di, w3pr);
  end

  always_comb begin
    a_r = ACC_W'(s1.ar);
    a_i = ACC_W'(s1.ai);
    b_r = ACC_W'(s1.brr) - ACC_W'(s1.bii);
    b_i = ACC_W'(s1.bri) + ACC_W'(s1.bir);
    c_r = ACC_W'(s1.crr) - ACC_W'(s1.cii);
    c_i = ACC_W'(s1.cri) + ACC_W'(s1.cir);
    d_r = ACC_W'(s1.drr) - ACC_W'(s1.dii);
    d_i = ACC_W'(s1.dri) + ACC_W'(s1.dir);
    s2_d       = '0;
    s2_d.s     = s1.s;
    s2_d.apc_r = a_r + c_r;
    s2_d.apc_i = a_i + c_i;
    s2_d.amc_r = a_r - c_r;
    s2_d.amc_i = a_i - c_i;
    s2_d.bpd_r = b_r + d_r;
    s2_d.bpd_i = b_i + d_i;
    s2_d.bmd_r = b_r - d_r;
    s2_d.bmd_i = b_i - d_i;
  end

  // F takes the -j rotation of (B-D) in forward mode, H the +j one.
  always_comb begin
    f_r     = s2.amc_r + s2.bmd_i;
    f_i     = s2.amc_i - s2.bmd_r;
    h_r     = s2.amc_r - s2.bmd_i;
    h_i     = s2.amc_i + s2.bmd_r;
    s3_d    = '0;
    s3_d.v  = s2.s.v;
    s3_d.sc = s2.s.sc;
    s3_d.er = s2.apc_r + s2.bpd_r;
    s3_d.ei = s2.apc_i + s2.bpd_i;
    s3_d.gr = s2.apc_r - s2.bpd_r;
    s3_d.gi = s2.apc_i - s2.bpd_i;
    if (s2.s.inv) begin
      s3_d.fr = h_r;
      s3_d.fi = h_i;
      s3_d.hr = f_r;
      s3_d.hi = f_i;
    end else begin
      s3_d.fr = f_r;
      s3_d.fi = f_i;
      s3_d.hr = h_r;
      s3_d.hi = h_i;
    end
  end

  always_comb begin
    rs[0]    = rnd_sat(s3.er, s3.sc);
    rs[1]    = rnd_sat(s3.ei, s3.sc);
    rs[2]    = rnd_sat(s3.fr, s3.sc);
    rs[3]    = rnd_sat(s3.fi, s3.sc);
    rs[4]    = rnd_sat(s3.gr, s3.sc);
    rs[5]    = rnd_sat(s3.gi, s3.sc);
    rs[6]    = rnd_sat(s3.hr, s3.sc);
    rs[7]    = rnd_sat(s3.hi, s3.sc);
    s4_d     = '0;
    s4_d.v   = s3.v;
    s4_d.er  = rs[0][IO-1:0];
    s4_d.ei  = rs[1][IO-1:0];
    s4_d.fr  = rs[2][IO-1:0];
    s4_d.fi  = rs[3][IO-1:0];
    s4_d.gr  = rs[4][IO-1:0];
    s4_d.gi  = rs[5][IO-1:0];
    s4_d.hr  = rs[6][IO-1:0];
    s4_d.hi  = rs[7][IO-1:0];
    for (int i = 0; i < 8; i++)
      s4_d.ovf = s4_d.ovf | rs[i][IO];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      s4 <= '0;
    end else if (enable) begin
      s1 <= s1_d;
      s2 <= s2_d;
      s3 <= s3_d;
      s4 <= s4_d;
    end
  end

  // Sticky rises together with the flagged out_valid sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ovf_sticky <= 1'b0;
    else if (ovf_clr)
      ovf_sticky <= 1'b0;
    else if (enable && s4_d.v && s4_d.ovf)
      ovf_sticky <= 1'b1;
  end

  assign out_valid = s4.v;
  assign ovf       = s4.ovf;
  assign er        = s4.er;
  assign ei        = s4.ei;
  assign fr        = s4.fr;
  assign fi        = s4.fi;
  assign gr        = s4.gr;
  assign gi        = s4.gi;
  assign hr        = s4.hr;
  assign hi        = s4.hi;

endmodule

// File: tb/tb_b4_unit_param.sv
// Scoreboard bench for b4_unit_param: directed vectors push
// expected results, a monitor pops them on each output sample.
module tb_b4_unit_param;

  logic        clk = 1'b0;
  logic        rst, enable, in_valid, inv, ovf_clr;
  logic [1:0]  scale_sel;
  logic [15:0] ar, ai, br, bi, cr, ci, dr, di;
  logic [8:0]  w1pr, w1pi, w2pr, w2pi, w3pr, w3pi;
  logic        out_valid, ovf, ovf_sticky;
  logic [15:0] er, ei, fr, fi, gr, gi, hr, hi;

  always #5 clk = ~clk;

  b4_unit_param dut (
    .clk(clk), .rst(rst), .enable(enable),
    .in_valid(in_valid), .inv(inv), .scale_sel(scale_sel),
    .ar(ar), .ai(ai), .br(br), .bi(bi),
    .cr(cr), .ci(ci), .dr(dr), .di(di),
    .w1pr(w1pr), .w1pi(w1pi), .w2pr(w2pr),
    .w2pi(w2pi), .w3pr(w3pr), .w3pi(w3pi),
    .out_valid(out_valid),
    .er(er), .ei(ei), .fr(fr), .fi(fi),
    .gr(gr), .gi(gi), .hr(hr), .hi(hi),
    .ovf(ovf), .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky)
  );

  typedef struct packed {
    logic        inv;
    logic [1:0]  sc;
    logic        clr;
    logic [15:0] ar, ai, br, bi, cr, ci, dr, di;
    logic [8:0]  w1pr, w1pi, w2pr, w2pi, w3pr, w3pi;
  } in_t;

  typedef struct packed {
    logic [15:0] er, ei, fr, fi, gr, gi, hr, hi;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t dout, cur, last;
  int   checks = 0;
  int   fails = 0;
  logic [3:0] vm;
  logic sticky_m;
  logic adv, clr_s, iv_s, rst_s;

  assign dout = {er, ei, fr, fi, gr, gi, hr, hi, ovf};

  task automatic check(input string name,
                       input logic [159:0] act,
                       input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int e0, e1, e2, e3,
                              input int e4, e5, e6, e7,
                              input logic o);
    return {16'(e0), 16'(e1), 16'(e2), 16'(e3),
            16'(e4), 16'(e5), 16'(e6), 16'(e7), o};
  endfunction

  task automatic drive(input in_t v);
    inv = v.inv; scale_sel = v.sc; ovf_clr = v.clr;
    ar = v.ar; ai = v.ai; br = v.br; bi = v.bi;
    cr = v.cr; ci = v.ci; dr = v.dr; di = v.di;
    w1pr = v.w1pr; w1pi = v.w1pi; w2pr = v.w2pr;
    w2pi = v.w2pi; w3pr = v.w3pr; w3pi = v.w3pi;
  endtask

  task automatic send(input in_t v, input exp_t e);
    @(negedge clk);
    drive(v);
    in_valid = 1'b1;
    enable   = 1'b1;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      enable   = 1'b1;
      ovf_clr  = 1'b0;
    end
  endtask

  task automatic pass(input int a);
    in_t v;
    v = '0;
    v.ar = 16'(a);
    send(v, mk(a, 0, a, 0, a, 0, a, 0, 1'b0));
  endtask

  // Monitor: a valid-bit shadow pipeline tells when a sample is due.
  initial begin
    vm = '0;
    sticky_m = 1'b0;
    last = '0;
    forever begin
      @(posedge clk);
      adv = enable; clr_s = ovf_clr; iv_s = in_valid; rst_s = rst;
      #1;
      if (!rst_s) begin
        vm = '0;
        sticky_m = 1'b0;
      end else begin
        if (adv) vm = {vm[2:0], iv_s};
        check("out_valid", 160'(out_valid), 160'(vm[3]));
        if (vm[3] && adv) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 160'(1), 160'(0));
          end else begin
            cur = sb.pop_front();
            last = cur;
            check("data", 160'(dout), 160'(cur));
          end
        end else if (vm[3]) begin
          check("hold", 160'(dout), 160'(last));
        end
        sticky_m = clr_s ? 1'b0 :
                   (sticky_m | (adv & vm[3] & last.ovf));
        check("ovf_sticky", 160'(ovf_sticky), 160'(sticky_m));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    in_t v;
    rst = 1'b0;
    enable = 1'b0;
    in_valid = 1'b0;
    drive('0);
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", {out_valid, dout, ovf_sticky}, '0);
    @(negedge clk);
    rst = 1'b1;

    pass(100);
    v = '0; v.br = 16'd1000; v.w1pr = 9'd255;
    send(v, mk(996, 0, 0, -996, -996, 0, 0, 996, 1'b0));
    v.inv = 1'b1;
    send(v, mk(996, 0, 0, 996, -996, 0, 0, -996, 1'b0));
    v = '0; v.dr = 16'd300; v.w3pr = 9'd255;
    send(v, mk(299, 0, 0, 299, -299, 0, 0, -299, 1'b0));
    v = '0; v.ci = 16'd400; v.w2pi = 9'd128;
    send(v, mk(-200, 0, 200, 0, -200, 0, 200, 0, 1'b0));
    v = '0; v.ar = 16'd102; v.sc = 2'd2;
    send(v, mk(26, 0, 26, 0, 26, 0, 26, 0, 1'b0));
    v.ar = 16'(-102);
    send(v, mk(-25, 0, -25, 0, -25, 0, -25, 0, 1'b0));
    v.ar = 16'd102; v.sc = 2'd3;
    send(v, mk(26, 0, 26, 0, 26, 0, 26, 0, 1'b0));
    v = '0; v.ar = 16'd3; v.sc = 2'd1;
    send(v, mk(2, 0, 2, 0, 2, 0, 2, 0, 1'b0));

    v = '0; v.ar = 16'd32767; v.br = 16'd32767; v.w1pr = 9'd255;
    send(v, mk(32767, 0, 32767, -32639, 128, 0,
               32767, 32639, 1'b1));
    for (int k = 1; k <= 5; k++) pass(k);
    v = '0; v.ar = 16'd6; v.clr = 1'b1;
    send(v, mk(6, 0, 6, 0, 6, 0, 6, 0, 1'b0));
    v = '0; v.ar = 16'h8000; v.br = 16'h8000; v.w1pr = 9'd255;
    send(v, mk(-32768, 0, -32768, 32640, -128, 0,
               -32768, -32640, 1'b1));

    pass(10);
    pass(20);
    v = '0; v.ar = 16'd30;
    @(negedge clk);
    drive(v);
    in_valid = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    pass(30);
    pass(40);
    idle(1);
    pass(50);
    pass(60);
    idle(8);

    pass(7);
    pass(8);
    pass(9);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("reset_mid", {out_valid, dout, ovf_sticky}, '0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(6);
    pass(-11);
    idle(8);

    check("sb_empty", 160'(sb.size()), 160'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/b4_unit_param.md
Name: b4_unit_param

Overview:
- Parametrised, pipelined radix-4 DIT butterfly for the FFT/IFFT datapath. It is the successor to the fixed 16/9-bit butterfly unit.
- Adds the following beyond that unit:
  - forward/inverse mode select;
  - per-transaction scaling (divide by 1, 2 or 4);
  - signed round-half-up with saturation instead of truncation;
  - valid tracking through the pipeline;
  - per-sample and sticky overflow flags.
- Sits between the twiddle ROM and the stage reorder memory of each radix-4 stage.

Parameters:
- WORDLENGTH_IO, 16, signed two's-complement data width of every I/O real/imag component.
- WORDLENGTH_WP, 9, signed twiddle width. Format Q1.(WORDLENGTH_WP-1); unity ≈ 2^(WORDLENGTH_WP-1)-1.
- ACC_W, WORDLENGTH_IO+WORDLENGTH_WP+3, internal accumulator width. Must not be set smaller.

Ports:
- clk, input, 1, system clock; all state on rising edge.
- rst, input, 1, asynchronous active-low reset.
- enable, input, 1, global clock enable. When 0, every pipeline register, including valid, holds its value.
- in_valid, input, 1, inputs are a valid butterfly operand set this cycle.
- inv, input, 1, 0 = forward transform (−j rotation), 1 = inverse (+j); captured with the data.
- scale_sel, input, 2, extra right shift: 0, 1 or 2. Value 3 is treated as 2. Captured with the data.
- ar,ai,br,bi,cr,ci,dr,di, input, WORDLENGTH_IO each, operands A..D.
- w1pr,w1pi,w2pr,w2pi,w3pr,w3pi, input, WORDLENGTH_WP each, twiddles for B, C, D.
- out_valid, output, 1, outputs er..hi are valid.
- er,ei,fr,fi,gr,gi,hr,hi, output, WORDLENGTH_IO each, butterfly results, signed.
- ovf, output, 1, at least one of the 8 output components saturated on this out_valid sample.
- ovf_clr, input, 1, synchronous clear of ovf_sticky. It has priority over a same-cycle set.
- ovf_sticky, output, 1, set when ovf=1 with out_valid=1; held until ovf_clr or reset.

Behaviour:
- Reset (rst=0, asynchronous) clears every pipeline register. Reset values: out_valid=0, all data outputs 0, ovf=0, ovf_sticky=0.
- A reset asserted mid-stream discards all in-flight samples. No out_valid is produced for them after reset release.
- Pipeline has 4 stages, each advancing only when enable=1. Latency is 4 enabled cycles from in_valid capture to out_valid. Throughput is one butterfly per enabled cycle.
- The sideband fields (valid, inv, scale_sel) shift alongside the data. A bubble (in_valid=0) propagates as out_valid=0, and data registers still update, so their contents are don't-care.
- S1, product stage: A is registered as a<<(WORDLENGTH_WP-1), exact. Register the 12 full signed products B=b*w1, C=c*w2, D=d*w3, real and imag cross terms, each WORDLENGTH_IO+WORDLENGTH_WP bits.
- S2, complex recombination and partial sums, sign-extended to ACC_W:
  - Form Br=brw1r−biw1i and Bi=brw1i+biw1r; likewise C and D.
  - Form A±C and B±D.
- S3, final sums:
  - E = A+B+C+D
  - G = A−B+C−D
  - F = A−C −j(B−D)
  - H = A−C +j(B−D)
  - When inv=1, F and H are swapped, giving a +j rotation on F.
- S4, output stage:
  - sh = WORDLENGTH_WP−1+scale_sel.
  - Rounding: y = (x + 2^(sh−1)) >>> sh, arithmetic shift, round half toward +inf.
  - Saturation: if y > 2^(WORDLENGTH_IO−1)−1, the output is that maximum; if y < −2^(WORDLENGTH_IO−1), the output is that minimum. Saturation is applied per component.
  - ovf is the OR of the 8 per-component saturation events and is registered with the data.
- ovf_sticky: next = ovf_clr ? 0 : (ovf_sticky | (out_valid & ovf & enable-advanced)). ovf_clr acts even when enable=0.
- No internal overflow is possible before S4 for any input combination, given ACC_W.
- Simultaneous in_valid and enable=0: the input is ignored, not captured. Upstream must hold the operand set until enable=1.

Test Plan:
1. Pass-through: ar=100, all others 0, scale_sel=0, inv=0. Four cycles later, out_valid=1 with er=fr=gr=hr=100 and all imag outputs 0.
2. Twiddle and rotation: br=1000, w1pr=255, all else 0.
   - Forward: er=996, fi=−996, gr=−996, hi=+996, remaining components 0, ovf=0.
   - Same stimulus with inv=1: fi=+996, hi=−996.
3. Scaling and rounding: ar=102, scale_sel=2 → er=26 (25.5 rounds up). ar=−102 → er=−25. scale_sel=3 gives the same result as 2.
4. Saturation: ar=32767, br=32767, w1pr=255, scale_sel=0 → er=32767, gr=128, ovf=1, ovf_sticky=1. The next sample with ovf_clr=1 clears ovf_sticky; with ovf_clr=0 it stays 1.
5. Stall and bubbles: 6 back-to-back valid samples with enable=0 for 3 cycles after sample 2.
   - Outputs and out_valid freeze during the stall.
   - All 6 results appear in order.
   - A 1-cycle in_valid gap produces exactly 1 out_valid=0 cycle.
6. Reset mid-stream: assert rst=0 with 3 samples in flight → all outputs 0 immediately. After release, no out_valid until a new in_valid plus 4 cycles.
